bus_beat_serializer: RTL and testbench

//  Parametrised bridge between a wide CPU bus and narrow chip pins. A CPU transfer (addr/wdata/we)
//  is sliced into PIN_W-bit beats, LSB beat first; reads collect data beats back from the pins.

---
 rtl/bus_beat_pkg.sv | 28 ++
 rtl/bus_beat_serializer_if.sv | 33 +++
 rtl/beat_counter.sv | 38 +++
 rtl/bus_beat_serializer.sv | 187 ++++++++++++++++++
 tb/tb_bus_beat_serializer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_beat_pkg.sv
// Shared types and elaboration-time helpers for the bus beat serializer.
package bus_beat_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StOut,
    StTa,
    StIn,
    StDone
  } state_e;

  function automatic int unsigned cdiv(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter must hold the largest beat/turnaround count of any phase.
  function automatic int unsigned cnt_width(input int unsigned no, input int unsigned nd,
                                            input int unsigned ta);
    int unsigned m;
    m = max_u(max_u(no, nd), ta);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bus_beat_serializer_if.sv
// CPU-side handshake plus pad-side pins of the bus beat serializer.
interface bus_beat_serializer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PIN_W  = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic [PIN_W-1:0]  pin_addr_out;
  logic [PIN_W-1:0]  pin_data_out;
  logic [PIN_W-1:0]  pin_data_in;
  logic [PIN_W-1:0]  pin_data_oe;
  logic              pin_sync;
  logic              pin_rd;
  logic              pin_wait;

  // Environment: CPU core plus pads.
  modport master (
    output req, we, addr, wdata, pin_data_in, pin_wait,
    input  rdata, ready, busy, pin_addr_out, pin_data_out, pin_data_oe, pin_sync, pin_rd
  );

  // The serializer itself.
  modport slave (
    input  req, we, addr, wdata, pin_data_in, pin_wait,
    output rdata, ready, busy, pin_addr_out, pin_data_out, pin_data_oe, pin_sync, pin_rd
  );
endinterface

// File: rtl/beat_counter.sv
// Clear/enable up-counter with terminal-count flag, reused by every beat phase.
module beat_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_next_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;
  assign tc_o       = (cnt_q == term_i);
endmodule

// File: rtl/bus_beat_serializer.sv
// Slices a wide CPU transfer into PIN_W-bit pin beats (LSB first) and gathers read beats back.
module bus_beat_serializer
  import bus_beat_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PIN_W      = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  bus_beat_serializer_if.slave bus
);
  localparam int unsigned NA    = cdiv(ADDR_W, PIN_W);
  localparam int unsigned ND    = cdiv(DATA_W, PIN_W);
  localparam int unsigned NO    = max_u(NA, ND);
  localparam int unsigned PadW  = NO * PIN_W;
  localparam int unsigned CNT_W = cnt_width(NO, ND, TURNAROUND);
  localparam logic [CNT_W-1:0] TermOut = CNT_W'(NO - 1);
  localparam logic [CNT_W-1:0] TermTa  = CNT_W'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);
  localparam logic [CNT_W-1:0] TermIn  = CNT_W'(ND - 1);

  if ((ADDR_W % PIN_W) != 0 || (DATA_W % PIN_W) != 0) begin : gen_width_err
    $error("bus_beat_serializer: ADDR_W and DATA_W must be multiples of PIN_W");
  end
  if (TURNAROUND > 7) begin : gen_ta_err
    $error("bus_beat_serializer: TURNAROUND must be in 0..7");
  end

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [PadW-1:0]   addr_q, addr_d;    // zero-padded to NO beats
  logic [PadW-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;    // read beats collected before commit
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d, busy_q, busy_d;
  logic              sync_q, sync_d, rd_q, rd_d;
  logic [PIN_W-1:0]  pa_q, pa_d, pd_q, pd_d, oe_q, oe_d;

  logic              cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]  cnt_term, cnt, cnt_next;
  logic [31:0]       out_off, in_off;

  beat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .term_i     (cnt_term),
    .cnt_o      (cnt),
    .cnt_next_o (cnt_next),
    .tc_o       (cnt_tc)
  );

  assign out_off = 32'(cnt_next) * PIN_W;
  assign in_off  = 32'(cnt) * PIN_W;

  // Phase sequencing, capture on acceptance and read-beat collection.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    rdata_d  = rdata_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_term = TermOut;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          state_d = StOut;
          we_d    = bus.we;
          addr_d  = PadW'(bus.addr);
          wdata_d = PadW'(bus.wdata);
          cnt_clr = 1'b1;
        end
      end
      StOut: begin
        cnt_term = TermOut;
        if (!bus.pin_wait) begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            if (we_q) begin
              state_d = StDone;
            end else begin
              state_d = (TURNAROUND == 0) ? StIn : StTa;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      StTa: begin
        cnt_term = TermTa;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = StIn;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StIn: begin
        cnt_term = TermIn;
        if (!bus.pin_wait) begin
          rbuf_d[in_off +: PIN_W] = bus.pin_data_in;
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            rdata_d = rbuf_d;  // rdata only changes once the whole word is in
            state_d = StDone;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pin and handshake values for the next cycle, decoded from next state and next beat.
  always_comb begin
    pa_d    = '0;
    pd_d    = '0;
    oe_d    = '0;
    sync_d  = 1'b0;
    rd_d    = (state_d == StIn);
    ready_d = (state_d == StDone);
    busy_d  = (state_d != StIdle);
    if (state_d == StOut) begin
      pa_d   = addr_d[out_off +: PIN_W];
      sync_d = (cnt_next == '0);
      if (we_d) begin
        pd_d = wdata_d[out_off +: PIN_W];
        oe_d = '1;
      end
    end
  end

  // FSM state, capture registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      sync_q  <= 1'b0;
      rd_q    <= 1'b0;
      pa_q    <= '0;
      pd_q    <= '0;
      oe_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      sync_q  <= sync_d;
      rd_q    <= rd_d;
      pa_q    <= pa_d;
      pd_q    <= pd_d;
      oe_q    <= oe_d;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.ready        = ready_q;
  assign bus.busy         = busy_q;
  assign bus.pin_addr_out = pa_q;
  assign bus.pin_data_out = pd_q;
  assign bus.pin_data_oe  = oe_q;
  assign bus.pin_sync     = sync_q;
  assign bus.pin_rd       = rd_q;
endmodule

// File: tb/tb_bus_beat_serializer.sv
// Randomised self-checking bench: default instance (32/32/8, TA=1) and narrow one (32/16/8, TA=0).
module tb_bus_beat_serializer;
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_beat_serializer_if #(.ADDR_W(32), .DATA_W(32), .PIN_W(8)) b0 ();
  bus_beat_serializer_if #(.ADDR_W(32), .DATA_W(16), .PIN_W(8)) b1 ();

  bus_beat_serializer #(
    .ADDR_W(32), .DATA_W(32), .PIN_W(8), .TURNAROUND(1)
  ) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b0)
  );

  bus_beat_serializer #(
    .ADDR_W(32), .DATA_W(16), .PIN_W(8), .TURNAROUND(0)
  ) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b1)
  );

  // One expected pin cycle: outputs to compare plus the stimulus to apply in that cycle.
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] oe;
    logic       sync;
    logic       rd;
    logic       rdy;
    logic       wt;
    logic [7:0] din;
  } rec_t;

  int          n_checks;
  int          n_errors;
  logic [31:0] rdata_model [2];
  int unsigned stall_out [8];
  int unsigned stall_in  [8];
  logic        use_force;
  logic [31:0] rd_force;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] obs(input int sel);
    if (sel == 0) begin
      return {b0.pin_addr_out, b0.pin_data_out, b0.pin_data_oe, b0.pin_sync, b0.pin_rd,
              b0.ready, b0.busy};
    end
    return {b1.pin_addr_out, b1.pin_data_out, b1.pin_data_oe, b1.pin_sync, b1.pin_rd,
            b1.ready, b1.busy};
  endfunction

  function automatic logic [31:0] obs_rdata(input int sel);
    return (sel == 0) ? b0.rdata : 32'(b1.rdata);
  endfunction

  function automatic logic [27:0] exp_of(input rec_t r);
    return {r.a, r.d, r.oe, r.sync, r.rd, r.rdy, 1'b1};
  endfunction

  function automatic rec_t mk(input logic [7:0] a, input logic [7:0] d, input logic [7:0] oe,
                              input logic sync, input logic rd, input logic rdy,
                              input logic wt, input logic [7:0] din);
    rec_t r;
    r.a = a; r.d = d; r.oe = oe; r.sync = sync; r.rd = rd; r.rdy = rdy; r.wt = wt; r.din = din;
    return r;
  endfunction

  task automatic drive(input int sel, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic wt, input logic [7:0] din);
    if (sel == 0) begin
      b0.req = req; b0.we = we; b0.addr = addr; b0.wdata = wdata;
      b0.pin_wait = wt; b0.pin_data_in = din;
    end else begin
      b1.req = req; b1.we = we; b1.addr = addr; b1.wdata = wdata[15:0];
      b1.pin_wait = wt; b1.pin_data_in = din;
    end
  endtask

  // One transfer from an idle DUT. Expected pin timeline is built beat by beat from the
  // transfer contents and the stall plan; abort_at >= 0 asserts reset in that cycle.
  task automatic run_xfer(input string name, input int sel, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata_in,
                          input logic hold, input int abort_at);
    rec_t        tl[$];
    logic [31:0] wdata;
    logic [31:0] rexp;
    logic [7:0]  rb;
    int          na, nd, ta, no;
    na    = 4;
    nd    = (sel == 0) ? 4 : 2;
    ta    = (sel == 0) ? 1 : 0;
    no    = (na > nd) ? na : nd;
    wdata = (sel == 0) ? wdata_in : (wdata_in & 32'h0000_FFFF);
    rexp  = '0;

    @(negedge clk);
    check($sformatf("%s idle", name), 64'(obs(sel)), 64'd0);
    check($sformatf("%s rdata_pre", name), 64'(obs_rdata(sel)), 64'(rdata_model[sel]));
    drive(sel, 1'b1, we, addr, wdata, 1'b0, 8'h00);

    for (int i = 0; i < no; i++) begin
      for (int k = 0; k <= int'(stall_out[i]); k++) begin
        tl.push_back(mk((i < na) ? addr[i*8 +: 8] : 8'h00,
                        (we && i < nd) ? wdata[i*8 +: 8] : 8'h00,
                        we ? 8'hFF : 8'h00, (i == 0), 1'b0, 1'b0,
                        (k < int'(stall_out[i])), 8'($urandom)));
      end
    end
    if (!we) begin
      for (int t = 0; t < ta; t++) begin
        tl.push_back(mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'($urandom), 8'($urandom)));
      end
      for (int i = 0; i < nd; i++) begin
        rb = use_force ? rd_force[i*8 +: 8] : 8'($urandom);
        rexp[i*8 +: 8] = rb;
        for (int k = 0; k <= int'(stall_in[i]); k++) begin
          tl.push_back(mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, (k < int'(stall_in[i])),
                          (k < int'(stall_in[i])) ? 8'($urandom) : rb));
        end
      end
    end
    tl.push_back(mk(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'($urandom), 8'($urandom)));

    for (int idx = 0; idx < tl.size(); idx++) begin
      @(negedge clk);
      check($sformatf("%s cyc%0d", name, idx), 64'(obs(sel)), 64'(exp_of(tl[idx])));
      if (idx == abort_at) begin
        rst = 1'b1;
        drive(sel, 1'b0, 1'b0, '0, '0, 1'b0, 8'h00);
        @(negedge clk);
        rdata_model[0] = '0;
        rdata_model[1] = '0;
        for (int s = 0; s < 2; s++) begin
          check($sformatf("%s rst_pins%0d", name, s), 64'(obs(s)), 64'd0);
          check($sformatf("%s rst_rdata%0d", name, s), 64'(obs_rdata(s)), 64'd0);
        end
        rst = 1'b0;
        return;
      end
      if (idx == tl.size() - 1) begin
        if (!we) rdata_model[sel] = rexp;
        check($sformatf("%s rdata", name), 64'(obs_rdata(sel)), 64'(rdata_model[sel]));
        drive(sel, hold, we, addr, wdata, tl[idx].wt, tl[idx].din);
      end else begin
        // Request and transfer inputs are scrambled while busy; none of it may take effect.
        drive(sel, 1'($urandom), 1'($urandom), $urandom, $urandom, tl[idx].wt, tl[idx].din);
      end
    end
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 8; i++) begin
      stall_out[i] = 0;
      stall_in[i]  = 0;
    end
  endtask

  initial begin
    logic        we, hold;
    logic [31:0] addr, wdata;
    int          sel;
    n_checks       = 0;
    n_errors       = 0;
    rdata_model[0] = '0;
    rdata_model[1] = '0;
    use_force      = 1'b0;
    rd_force       = '0;
    clear_stalls();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset_pins%0d", s), 64'(obs(s)), 64'd0);
      check($sformatf("reset_rdata%0d", s), 64'(obs_rdata(s)), 64'd0);
    end
    rst = 1'b0;

    run_xfer("wr_default", 0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, -1);

    use_force = 1'b1;
    rd_force  = 32'h4433_2211;
    run_xfer("rd_default", 0, 1'b0, 32'h0000_0010, '0, 1'b0, -1);
    check("rd_default value", 64'(obs_rdata(0)), 64'h4433_2211);

    stall_out[2] = 3;
    stall_in[1]  = 3;
    run_xfer("rd_stall", 0, 1'b0, 32'h0000_0010, '0, 1'b0, -1);
    check("rd_stall value", 64'(obs_rdata(0)), 64'h4433_2211);
    clear_stalls();

    // Cycle 7 is IN beat 2: four OUT beats, one turnaround, IN beats 0 and 1.
    run_xfer("rd_reset", 0, 1'b0, 32'h0000_0010, '0, 1'b0, 7);
    run_xfer("rd_after_reset", 0, 1'b0, 32'h0000_0010, '0, 1'b0, -1);
    check("rd_after_reset value", 64'(obs_rdata(0)), 64'h4433_2211);

    run_xfer("hold_first", 0, 1'b1, 32'hCAFE_0001, 32'h0BAD_F00D, 1'b1, -1);
    run_xfer("hold_second", 0, 1'b1, 32'hCAFE_0001, 32'h0BAD_F00D, 1'b0, -1);

    run_xfer("wr_narrow", 1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, -1);
    rd_force = 32'h0000_A55A;
    run_xfer("rd_narrow", 1, 1'b0, 32'h8765_4321, '0, 1'b0, -1);
    check("rd_narrow value", 64'(obs_rdata(1)), 64'h0000_A55A);
    use_force = 1'b0;

    for (int n = 0; n < 40; n++) begin
      sel   = int'($urandom_range(0, 1));
      we    = 1'($urandom);
      addr  = $urandom;
      wdata = $urandom;
      hold  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 8; i++) begin
        stall_out[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        stall_in[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      run_xfer($sformatf("rand%0d", n), sel, we, addr, wdata, hold, -1);
      if (hold) begin
        clear_stalls();
        run_xfer($sformatf("rand%0d_held", n), sel, we, addr, wdata, 1'b0, -1);
      end
    end

    @(negedge clk);
    check("final idle0", 64'(obs(0)), 64'd0);
    check("final idle1", 64'(obs(1)), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
